// File: rtl/fsm_ctrl_pkg.sv
// Shared op codes, controller state encoding, trace record layout and default widths
// for the fsm_step_ctrl step sequencer.
package fsm_ctrl_pkg;

    localparam int unsigned DEF_SW_W       = 2;
    localparam int unsigned DEF_ST_W       = 3;
    localparam int unsigned DEF_STIM_DEPTH = 8;
    localparam int unsigned DEF_CNT_W      = 16;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_STEP  = 2'd1,
        OP_RUN_N = 2'd2,
        OP_CLR   = 2'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_APPLY   = 3'd2,
        ST_STROBE  = 3'd3,
        ST_CAPTURE = 3'd4
    } ctrl_state_e;

    typedef struct packed {
        logic [DEF_SW_W-1:0] sw;
        logic [DEF_ST_W-1:0] state;
        logic                out;
    } trace_t;

endpackage

// File: rtl/fsm_step_ctrl_if.sv
// Host-facing handshake bundle of fsm_step_ctrl: command, stimulus push and trace stream.
// master = host/bench side, slave = controller side.
interface fsm_step_ctrl_if #(
    parameter int unsigned SW_W = 2,
    parameter int unsigned ST_W = 3
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_op;
    logic [7:0]           cmd_count;

    logic                 stim_valid;
    logic                 stim_ready;
    logic [SW_W-1:0]      stim_data;

    logic                 trace_valid;
    logic                 trace_ready;
    logic [SW_W+ST_W:0]   trace_data;

    modport master (
        output cmd_valid, cmd_op, cmd_count, stim_valid, stim_data, trace_ready,
        input  cmd_ready, stim_ready, trace_valid, trace_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_count, stim_valid, stim_data, trace_ready,
        output cmd_ready, stim_ready, trace_valid, trace_data
    );

endinterface

// File: rtl/fsm_step_ctrl_stim_fifo.sv
// Stimulus FIFO for fsm_step_ctrl: valid/ready push, pop strobe, empty flag and fill count.
// push_ready reflects the pre-pop full state, so a push while full is dropped even when popping.
module stim_fifo #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full       = (count_q == DEPTH[AW:0]);
    assign empty      = (count_q == '0);
    assign push_ready = !full;
    assign do_push    = push_valid && !full;
    assign do_pop     = pop && !empty;
    assign pop_data   = mem_q[rd_ptr_q];
    assign count      = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fsm_step_ctrl.sv
// Step sequencer driving one Moore FSM-under-test and streaming a {sw,state,out} trace per step.
// Optional breakpoint support (bkpt_en/bkpt_state/bkpt_hit) is built when FSM_BKPT_EN is defined.
module fsm_step_ctrl
    import fsm_ctrl_pkg::*;
#(
    parameter int unsigned SW_W       = DEF_SW_W,
    parameter int unsigned ST_W       = DEF_ST_W,
    parameter int unsigned STIM_DEPTH = DEF_STIM_DEPTH,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    fsm_step_ctrl_if.slave   bus,
    input  logic             halt,
    output logic [SW_W-1:0]  fsm_sw,
    output logic             fsm_ctrl,
    input  logic [ST_W-1:0]  fsm_state,
    input  logic             fsm_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] step_cnt
`ifdef FSM_BKPT_EN
    ,
    input  logic             bkpt_en,
    input  logic [ST_W-1:0]  bkpt_state,
    output logic             bkpt_hit
`endif
);

    ctrl_state_e             state_q, state_d;
    logic [7:0]              remaining_q, remaining_d;
    logic                    run_all_q, run_all_d;
    logic                    halt_pend_q, halt_pend_d;
    logic [SW_W-1:0]         sw_q, sw_d;
    logic [SW_W-1:0]         applied_sw_q, applied_sw_d;
    logic [CNT_W-1:0]        step_cnt_q, step_cnt_d;
    logic                    done_q, done_d;
    logic                    bkpt_stop;

    logic                    stim_pop;
    logic [SW_W-1:0]         stim_head;
    logic                    stim_empty;
    logic [$clog2(STIM_DEPTH):0] stim_count;

    stim_fifo #(
        .WIDTH (SW_W),
        .DEPTH (STIM_DEPTH)
    ) u_stim_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_valid (bus.stim_valid),
        .push_ready (bus.stim_ready),
        .push_data  (bus.stim_data),
        .pop        (stim_pop),
        .pop_data   (stim_head),
        .empty      (stim_empty),
        .count      (stim_count)
    );

`ifdef FSM_BKPT_EN
    logic bkpt_hit_q, bkpt_hit_d;
    assign bkpt_stop = bkpt_en && (fsm_state == bkpt_state);
    assign bkpt_hit  = bkpt_hit_q;
`else
    assign bkpt_stop = 1'b0;
`endif

    assign bus.cmd_ready   = (state_q == ST_IDLE);
    assign bus.trace_valid = (state_q == ST_CAPTURE);
    assign bus.trace_data  = {sw_q, fsm_state, fsm_out};
    assign fsm_ctrl        = (state_q == ST_STROBE);
    assign fsm_sw          = sw_q;
    assign busy            = (state_q != ST_IDLE);
    assign done            = done_q;
    assign step_cnt        = step_cnt_q;

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        run_all_d    = run_all_q;
        halt_pend_d  = halt_pend_q;
        sw_d         = sw_q;
        applied_sw_d = applied_sw_q;
        step_cnt_d   = step_cnt_q;
        stim_pop     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    unique case (cmd_op_e'(bus.cmd_op))
                        OP_STEP: begin
                            remaining_d = 8'd1;
                            run_all_d   = 1'b0;
                            halt_pend_d = 1'b0;
                            state_d     = ST_FETCH;
                        end
                        OP_RUN_N: begin
                            remaining_d = bus.cmd_count;
                            run_all_d   = (bus.cmd_count == 8'd0);
                            halt_pend_d = 1'b0;
                            state_d     = ST_FETCH;
                        end
                        OP_CLR:  step_cnt_d = '0;
                        default: ;
                    endcase
                end
            end
            ST_FETCH: begin
                if (halt) begin
                    state_d = ST_IDLE;
                end else if (stim_count != '0) begin
                    stim_pop = 1'b1;
                    sw_d     = stim_head;
                    state_d  = ST_APPLY;
                end else if (run_all_q && stim_empty) begin
                    state_d = ST_IDLE;
                end
            end
            ST_APPLY: begin
                // An aborted step must leave fsm_sw at the last value actually strobed.
                if (halt) begin
                    sw_d    = applied_sw_q;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STROBE;
                end
            end
            ST_STROBE: begin
                halt_pend_d  = halt_pend_q | halt;
                applied_sw_d = sw_q;
                state_d      = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                halt_pend_d = halt_pend_q | halt;
                if (bus.trace_ready) begin
                    step_cnt_d = (&step_cnt_q) ? step_cnt_q : step_cnt_q + CNT_W'(1);
                    if (!run_all_q) begin
                        remaining_d = remaining_q - 8'd1;
                    end
                    if (halt_pend_q || halt || bkpt_stop || (!run_all_q && remaining_q == 8'd1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        done_d = (state_q != ST_IDLE) && (state_d == ST_IDLE);
    end

`ifdef FSM_BKPT_EN
    always_comb begin
        bkpt_hit_d = (state_q == ST_CAPTURE) && bus.trace_ready && bkpt_stop;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bkpt_hit_q <= 1'b0;
        end else begin
            bkpt_hit_q <= bkpt_hit_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            remaining_q  <= '0;
            run_all_q    <= 1'b0;
            halt_pend_q  <= 1'b0;
            sw_q         <= '0;
            applied_sw_q <= '0;
            step_cnt_q   <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            run_all_q    <= run_all_d;
            halt_pend_q  <= halt_pend_d;
            sw_q         <= sw_d;
            applied_sw_q <= applied_sw_d;
            step_cnt_q   <= step_cnt_d;
            done_q       <= done_d;
        end
    end

endmodule
